pipelined_control_unit: RTL and testbench

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

---
 rtl/cu_pkg.sv | 60 ++++++
 rtl/control_decoder.sv | 97 +++++++++
 rtl/pipelined_control_unit.sv | 108 ++++++++++
 tb/tb_pipelined_control_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcode, funct7, selector encodings, control bundle and FSM state for the control unit
package cu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] IMM_U = 3'b000;
    localparam logic [2:0] IMM_J = 3'b001;
    localparam logic [2:0] IMM_I = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_S = 3'b100;

    localparam logic [1:0] RWS_PC4 = 2'b00;
    localparam logic [1:0] RWS_MEM = 2'b01;
    localparam logic [1:0] RWS_ALU = 2'b10;

    typedef enum logic {
        IDLE     = 1'b0,
        MDU_WAIT = 1'b1
    } cu_state_t;

    typedef struct packed {
        logic [4:0] alu_sel;
        logic [2:0] immediate_sel;
        logic       operand1_sel;
        logic       operand2_sel;
        logic [3:0] branch_sel;
        logic [3:0] mem_read;
        logic [2:0] mem_write;
        logic [1:0] reg_write_sel;
        logic       reg_write_en;
        logic       illegal;
    } ctrl_t;

    // Bubble / reset bundle: nothing written, nothing accessed, ALU result path selected.
    localparam ctrl_t CTRL_BUBBLE = '{
        alu_sel:       5'd0,
        immediate_sel: 3'd0,
        operand1_sel:  1'b0,
        operand2_sel:  1'b0,
        branch_sel:    4'd0,
        mem_read:      4'd0,
        mem_write:     3'd0,
        reg_write_sel: RWS_ALU,
        reg_write_en:  1'b0,
        illegal:       1'b0
    };

endpackage

// File: rtl/control_decoder.sv
// rtl/control_decoder.sv - combinational RV32I(+M) instruction to control bundle decode
// Ports: opcode/funct3/funct7 in (instruction fields); ctrl out (decoded bundle);
//        mdu_op out (instruction is a multiply/divide op that must be sequenced).
// Build option: RV32M_EN defined decodes RV32M, undefined treats RV32M as illegal.
module control_decoder
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic       mdu_op
);

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_op_imm, is_op, is_m;
    logic known, m_bad, bad;

    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_op_imm = (opcode == OPC_OP_IMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_m      = is_op && (funct7 == F7_MULDIV);

    assign known = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                   is_load | is_store | is_op_imm | is_op;

`ifdef RV32M_EN
    assign mdu_op = is_m;
    assign m_bad  = 1'b0;
`else
    assign mdu_op = 1'b0;
    assign m_bad  = is_m;
`endif

    assign bad = ~known | m_bad;

    always_comb begin
        ctrl = CTRL_BUBBLE;

        if (is_lui | is_auipc | is_jal | is_branch | is_load | is_store)
            ctrl.alu_sel[2:0] = 3'b000;
        else if (is_jalr)
            ctrl.alu_sel[2:0] = 3'b001;
        else
            ctrl.alu_sel[2:0] = funct3;
        ctrl.alu_sel[3] = is_lui | mdu_op;
        // SUB/SRA and SRAI are the funct7=0100000 variants of ADD/SRL/SRLI.
        ctrl.alu_sel[4] = is_lui | is_jalr |
                          (is_op && funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) |
                          (is_op_imm && funct7 == F7_ALT && funct3 == 3'b101);

        if (is_jal)
            ctrl.immediate_sel = IMM_J;
        else if (is_op_imm | is_jalr | is_load)
            ctrl.immediate_sel = IMM_I;
        else if (is_branch)
            ctrl.immediate_sel = IMM_B;
        else if (is_store)
            ctrl.immediate_sel = IMM_S;
        else
            ctrl.immediate_sel = IMM_U;

        ctrl.operand1_sel = is_auipc | is_jal | is_branch;
        ctrl.operand2_sel = ~is_op;

        if (is_jal | is_jalr)
            ctrl.branch_sel = 4'b1010;
        else
            ctrl.branch_sel = {is_branch, funct3};
        ctrl.mem_read  = {is_load, funct3};
        ctrl.mem_write = {is_store, funct3[1:0]};

        if (is_jal | is_jalr)
            ctrl.reg_write_sel = RWS_PC4;
        else if (is_load)
            ctrl.reg_write_sel = RWS_MEM;
        else
            ctrl.reg_write_sel = RWS_ALU;
        ctrl.reg_write_en = ~(is_branch | is_store);

        // An illegal encoding must never write, access memory or redirect.
        if (bad) begin
            ctrl.reg_write_en  = 1'b0;
            ctrl.mem_read[3]   = 1'b0;
            ctrl.mem_write[2]  = 1'b0;
            ctrl.branch_sel[3] = 1'b0;
        end
        ctrl.illegal = bad;
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - registered decode stage with fetch handshake, stall/flush and MDU sequencing
// Ports: CLK, RESET (sync, active-high); Instruction/in_valid/in_ready fetch handshake;
//        stall, flush pipeline controls; out_valid plus registered control bundle
//        (ALU_sel, immediate_sel, operand1_sel, operand2_sel, branch_sel, mem_read,
//        mem_write, reg_write_sel, reg_write_EN, illegal); mdu_busy.
// Build option: RV32M_EN enables RV32M decode and the MDU_WAIT state/counter.
module pipelined_control_unit
    import cu_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instruction,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [4:0]  ALU_sel,
    output logic [2:0]  immediate_sel,
    output logic        operand1_sel,
    output logic        operand2_sel,
    output logic [3:0]  branch_sel,
    output logic [3:0]  mem_read,
    output logic [2:0]  mem_write,
    output logic [1:0]  reg_write_sel,
    output logic        reg_write_EN,
    output logic        illegal,
    output logic        mdu_busy
);

    if (MDU_LATENCY < 1 || MDU_LATENCY > 32 || CNT_W < $clog2(MDU_LATENCY)) begin : g_bad_cfg
        $error("pipelined_control_unit: bad MDU_LATENCY/CNT_W");
    end

    ctrl_t dec, ctrl_q;
    logic  mdu_op, idle, accept;
    logic  unused_bits;

    control_decoder u_decoder (
        .opcode (Instruction[6:0]),
        .funct3 (Instruction[14:12]),
        .funct7 (Instruction[31:25]),
        .ctrl   (dec),
        .mdu_op (mdu_op)
    );

    assign unused_bits = ^{Instruction[24:15], Instruction[11:7], mdu_op};

    assign in_ready = ~stall & idle & ~RESET;
    assign accept   = in_valid & in_ready & ~flush;

`ifdef RV32M_EN
    cu_state_t        state;
    logic [CNT_W-1:0] mdu_cnt;

    // The counter runs even while stalled: the MDU makes progress independently
    // of downstream holds. Leaving on count 1 makes the exit coincide with 0.
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            state   <= IDLE;
            mdu_cnt <= '0;
        end else if (state == MDU_WAIT) begin
            mdu_cnt <= mdu_cnt - 1'b1;
            if (mdu_cnt == CNT_W'(1))
                state <= IDLE;
        end else if (accept && mdu_op && MDU_LATENCY > 1) begin
            state   <= MDU_WAIT;
            mdu_cnt <= CNT_W'(MDU_LATENCY - 1);
        end
    end

    assign idle     = (state == IDLE);
    assign mdu_busy = (state == MDU_WAIT);
`else
    assign idle     = 1'b1;
    assign mdu_busy = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            out_valid <= 1'b0;
            ctrl_q    <= CTRL_BUBBLE;
        end else if (!stall) begin
            if (accept) begin
                out_valid <= 1'b1;
                ctrl_q    <= dec;
            end else begin
                out_valid <= 1'b0;
                ctrl_q    <= CTRL_BUBBLE;
            end
        end
    end

    assign ALU_sel       = ctrl_q.alu_sel;
    assign immediate_sel = ctrl_q.immediate_sel;
    assign operand1_sel  = ctrl_q.operand1_sel;
    assign operand2_sel  = ctrl_q.operand2_sel;
    assign branch_sel    = ctrl_q.branch_sel;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign reg_write_sel = ctrl_q.reg_write_sel;
    assign reg_write_EN  = ctrl_q.reg_write_en;
    assign illegal       = ctrl_q.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - randomized bench with behavioural model for pipelined_control_unit
module tb_pipelined_control_unit;

    localparam int LAT = 4;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] I_MUL  = 32'h022081B3;

    // {ALU, imm, op1, op2, branch, mem_read, mem_write, rws, rwe, illegal}
    localparam logic [24:0] B_BUB   = 25'b00000_000_0_0_0000_0000_000_10_0_0;
    localparam logic [24:0] B_ADDI  = 25'b00000_010_0_1_0000_0000_000_10_1_0;
    localparam logic [24:0] B_SW    = 25'b00000_100_0_1_0010_0010_110_10_0_0;
    localparam logic [24:0] B_BAD   = 25'b00111_000_0_1_0111_0111_011_10_0_1;
    localparam logic [24:0] B_MUL   = 25'b01000_000_0_0_0000_0000_000_10_1_0;
    localparam logic [24:0] B_MULX  = 25'b00000_000_0_0_0000_0000_000_10_0_1;

    logic        CLK = 1'b0;
    logic        RESET, in_valid, stall, flush;
    logic [31:0] Instruction;
    logic        in_ready, out_valid, operand1_sel, operand2_sel, reg_write_EN, illegal, mdu_busy;
    logic [4:0]  ALU_sel;
    logic [2:0]  immediate_sel, mem_write;
    logic [3:0]  branch_sel, mem_read;
    logic [1:0]  reg_write_sel;

    int total = 0;
    int bad   = 0;

    logic [24:0] m_ctrl = B_BUB;
    bit          m_valid = 1'b0;
    int          m_busy = 0;

    always #5 CLK = ~CLK;

    pipelined_control_unit #(.MDU_LATENCY(LAT), .CNT_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .Instruction(Instruction), .in_valid(in_valid),
        .in_ready(in_ready), .stall(stall), .flush(flush), .out_valid(out_valid),
        .ALU_sel(ALU_sel), .immediate_sel(immediate_sel), .operand1_sel(operand1_sel),
        .operand2_sel(operand2_sel), .branch_sel(branch_sel), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write_sel(reg_write_sel), .reg_write_EN(reg_write_EN),
        .illegal(illegal), .mdu_busy(mdu_busy)
    );

    function automatic logic [24:0] bundle();
        return {ALU_sel, immediate_sel, operand1_sel, operand2_sel, branch_sel,
                mem_read, mem_write, reg_write_sel, reg_write_EN, illegal};
    endfunction

    function automatic bit is_mdu(input logic [31:0] ins);
        return ins[6:0] == 7'h33 && ins[31:25] == 7'h01;
    endfunction

    // Rule-by-rule decode written straight from the instruction-class table.
    function automatic logic [24:0] model_decode(input logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        bit lui = op == 7'h37, auipc = op == 7'h17, jal = op == 7'h6F, jalr = op == 7'h67;
        bit br = op == 7'h63, ld = op == 7'h03, st = op == 7'h23, opi = op == 7'h13, rr = op == 7'h33;
        bit m = is_mdu(ins);
        bit ill = !(lui || auipc || jal || jalr || br || ld || st || opi || rr) || (m && !M_EN);
        logic [4:0] alu;
        logic [2:0] imm;
        logic [3:0] bsel;
        logic [1:0] rws;
        alu[2:0] = (lui || auipc || jal || br || ld || st) ? 3'd0 : (jalr ? 3'd1 : f3);
        alu[3]   = lui || (m && M_EN);
        alu[4]   = lui || jalr || (f7 == 7'h20 && ((rr && (f3 == 0 || f3 == 5)) || (opi && f3 == 5)));
        imm  = jal ? 3'd1 : (opi || jalr || ld) ? 3'd2 : br ? 3'd3 : st ? 3'd4 : 3'd0;
        bsel = (jal || jalr) ? 4'b1010 : {br, f3};
        rws  = (jal || jalr) ? 2'b00 : ld ? 2'b01 : 2'b10;
        return {alu, imm, 1'(auipc || jal || br), 1'(!rr), bsel, {ld && !ill, f3},
                {st && !ill, f3[1:0]}, rws, 1'(!(br || st || ill)), 1'(ill)};
    endfunction

    function automatic bit model_ready();
        return !stall && m_busy == 0 && !RESET;
    endfunction

    task automatic model_step();
        bit acc = in_valid && model_ready() && !flush;
        if (RESET || flush) begin
            m_valid = 0; m_ctrl = B_BUB; m_busy = 0;
        end else begin
            if (m_busy > 0) m_busy--;
            if (!stall) begin
                if (acc) begin
                    m_valid = 1;
                    m_ctrl  = model_decode(Instruction);
                    if (M_EN && is_mdu(Instruction) && LAT > 1) m_busy = LAT - 1;
                end else begin
                    m_valid = 0; m_ctrl = B_BUB;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check in_ready, let the edge happen, compare at negedge.
    task automatic cycle(input logic r, input logic v, input logic s, input logic f,
                         input logic [31:0] ins);
        RESET = r; in_valid = v; stall = s; flush = f; Instruction = ins;
        #1;
        chk("in_ready", 32'(in_ready), 32'(model_ready()));
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("bundle", 32'(bundle()), 32'(m_ctrl));
        chk("mdu_busy", 32'(mdu_busy), 32'(m_busy > 0));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        case ($urandom_range(0, 10))
            0: ins[6:0] = 7'h37;  1: ins[6:0] = 7'h17;  2: ins[6:0] = 7'h6F;
            3: ins[6:0] = 7'h67;  4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h03;
            6: ins[6:0] = 7'h23;  7: ins[6:0] = 7'h13;  8: ins[6:0] = 7'h33;
            9: ins[6:0] = 7'h33;  default: ;
        endcase
        case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;  1: ins[31:25] = 7'h20;  2: ins[31:25] = 7'h01;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        cycle(1, 0, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, I_ADDI);
        chk("reset_bundle", 32'(bundle()), 32'(B_BUB));
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(mdu_busy), 32'd0);

        cycle(0, 1, 0, 0, I_ADDI);
        chk("addi_bundle", 32'(bundle()), 32'(B_ADDI));
        chk("addi_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 1, 0, I_SW);
            chk("stall_hold", 32'(bundle()), 32'(B_ADDI));
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        cycle(0, 1, 0, 0, I_SW);
        chk("sw_bundle", 32'(bundle()), 32'(B_SW));
        cycle(0, 0, 0, 0, I_SW);
        chk("bubble_bundle", 32'(bundle()), 32'(B_BUB));
        chk("bubble_valid", 32'(out_valid), 32'd0);
        cycle(0, 1, 0, 0, I_BAD);
        chk("bad_bundle", 32'(bundle()), 32'(B_BAD));

        cycle(0, 1, 0, 0, I_MUL);
`ifdef RV32M_EN
        chk("mul_bundle", 32'(bundle()), 32'(B_MUL));
        chk("mul_valid", 32'(out_valid), 32'd1);
        chk("mul_busy", 32'(mdu_busy), 32'd1);
        chk("mul_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, 0, I_ADDI);
            chk("mul_wait_busy", 32'(mdu_busy), 32'(k < 2));
            chk("mul_wait_valid", 32'(out_valid), 32'd0);
        end
        chk("mul_done_ready", 32'(in_ready), 32'd1);
        cycle(0, 1, 0, 0, I_MUL);
        cycle(0, 0, 1, 0, I_ADDI);
        cycle(0, 0, 1, 1, I_ADDI);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(mdu_busy), 32'd0);
        stall = 0; flush = 0; #1;
        chk("flush_ready", 32'(in_ready), 32'd1);
`else
        chk("mulx_bundle", 32'(bundle()), 32'(B_MULX));
        chk("mulx_valid", 32'(out_valid), 32'd1);
        chk("mulx_busy", 32'(mdu_busy), 32'd0);
        chk("mulx_ready", 32'(in_ready), 32'd1);
        cycle(0, 1, 0, 0, I_ADDI);
        chk("mulx_nobubble", 32'(out_valid), 32'd1);
`endif
        cycle(0, 1, 0, 0, I_MUL);
        cycle(1, 1, 1, 0, I_ADDI);
        chk("reset_abort_busy", 32'(mdu_busy), 32'd0);
        cycle(0, 0, 0, 0, I_ADDI);
        chk("reset_abort_valid", 32'(out_valid), 32'd0);

        for (int n = 0; n < 3000; n++)
            cycle(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 70),
                  1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 6), rand_instr());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
